// File: rtl/lht_access_scheduler_if.sv
// ---------------------------------------------------------------------------
// lht_access_scheduler_if
// Bundles the three buses around the LHT access scheduler:
//   lookup  : lk_valid/lk_ready/lk_pc request, lk_rsp_valid/lk_rsp_hist response
//   update  : upd_valid/upd_ready/upd_pc/upd_taken resolved-branch requests
//   table   : tbl_addr/tbl_rd_en/tbl_wr_en/tbl_wdata to the single-ported
//             array, tbl_rdata back (1-cycle read latency)
// Modports:
//   slave  - the scheduler side
//   master - the surrounding logic / storage side
// ---------------------------------------------------------------------------
interface lht_access_scheduler_if #(
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned HIST_W = 10
);
  logic              lk_valid;
  logic              lk_ready;
  logic [IDX_W-1:0]  lk_pc;
  logic              lk_rsp_valid;
  logic [HIST_W-1:0] lk_rsp_hist;

  logic              upd_valid;
  logic              upd_ready;
  logic [IDX_W-1:0]  upd_pc;
  logic              upd_taken;

  logic [IDX_W-1:0]  tbl_addr;
  logic              tbl_rd_en;
  logic              tbl_wr_en;
  logic [HIST_W-1:0] tbl_wdata;
  logic [HIST_W-1:0] tbl_rdata;

  modport slave (
    input  lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, tbl_rdata,
    output lk_ready, lk_rsp_valid, lk_rsp_hist, upd_ready,
           tbl_addr, tbl_rd_en, tbl_wr_en, tbl_wdata
  );

  modport master (
    output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, tbl_rdata,
    input  lk_ready, lk_rsp_valid, lk_rsp_hist, upd_ready,
           tbl_addr, tbl_rd_en, tbl_wr_en, tbl_wdata
  );
endinterface

// File: rtl/lht_access_scheduler.sv
// ---------------------------------------------------------------------------
// lht_access_scheduler
// Sequences every access to a single-ported local history table: a clear
// sweep after reset, predict-time lookups, and resolve-time read-modify-write
// history updates buffered in a small FIFO.
//
// Parameters:
//   IDX_W   table index width (2**IDX_W entries)
//   HIST_W  history bits per entry
//   QDEPTH  pending-update queue depth (power of 2, >= 2)
// Ports:
//   clock      single clock, posedge
//   reset      synchronous, active-high
//   init_done  clear sweep finished (sticky until reset)
//   bus        lht_access_scheduler_if.slave: lookup, update and table buses
// Optional feature (macro LHT_STATS_EN):
//   stat_lookups / stat_updates / stat_stalls, 32-bit saturating counters.
// ---------------------------------------------------------------------------
module lht_access_scheduler #(
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned HIST_W = 10,
  parameter int unsigned QDEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  output logic init_done,
`ifdef LHT_STATS_EN
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_stalls,
`endif
  lht_access_scheduler_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LK_WAIT,
    UP_WAIT,
    UP_WR
  } state_t;

  state_t            state, state_d;
  logic [IDX_W-1:0]  ptr;

  logic [IDX_W-1:0]  q_pc    [QDEPTH];
  logic              q_taken [QDEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic [HIST_W-1:0] hist_q;
  logic              rsp_valid;
  logic [HIST_W-1:0] rsp_hist;

  logic              full, empty, urgent;
  logic              lk_ready, upd_ready;
  logic              lk_fire, push, pop;

  logic [IDX_W-1:0]  addr;
  logic              rd_en, wr_en;
  logic [HIST_W-1:0] wdata;

  assign full   = (count == CNT_W'(QDEPTH));
  assign empty  = (count == '0);
  // One slot of headroom left: stop admitting lookups so the queue drains
  // before it fills and back-pressures the resolve logic.
  assign urgent = (count >= CNT_W'(QDEPTH - 1));

  assign lk_ready  = !reset && (state == IDLE) && init_done && !urgent;
  assign upd_ready = !reset && init_done && !full;
  assign lk_fire   = bus.lk_valid && lk_ready;
  assign push      = bus.upd_valid && upd_ready;

  always_comb begin
    state_d = state;
    addr    = '0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wdata   = '0;
    pop     = 1'b0;
    unique case (state)
      INIT: begin
        wr_en = 1'b1;
        addr  = ptr;
        if (ptr == '1) state_d = IDLE;
      end
      IDLE: begin
        if (lk_fire) begin
          rd_en   = 1'b1;
          addr    = bus.lk_pc;
          state_d = LK_WAIT;
        end else if (!empty) begin
          rd_en   = 1'b1;
          addr    = q_pc[head];
          state_d = UP_WAIT;
        end
      end
      LK_WAIT: state_d = IDLE;
      UP_WAIT: state_d = UP_WR;
      UP_WR: begin
        wr_en   = 1'b1;
        addr    = q_pc[head];
        wdata   = {hist_q[HIST_W-2:0], q_taken[head]};
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
    // A reset landing mid-access must not let the table see a stray strobe.
    if (reset) begin
      addr  = '0;
      rd_en = 1'b0;
      wr_en = 1'b0;
      wdata = '0;
      pop   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      ptr       <= '0;
      init_done <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      hist_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_hist  <= '0;
    end else begin
      state <= state_d;
      if (state == INIT) begin
        ptr <= ptr + IDX_W'(1);
        if (ptr == '1) init_done <= 1'b1;
      end
      if (state == UP_WAIT) hist_q <= bus.tbl_rdata;
      rsp_valid <= (state == LK_WAIT);
      if (state == LK_WAIT) rsp_hist <= bus.tbl_rdata;
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Queue storage needs no reset: head/tail/count define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[tail]    <= bus.upd_pc;
      q_taken[tail] <= bus.upd_taken;
    end
  end

`ifdef LHT_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_lookups <= '0;
      stat_updates <= '0;
      stat_stalls  <= '0;
    end else begin
      if (lk_fire && (stat_lookups != '1))
        stat_lookups <= stat_lookups + 32'd1;
      if ((state == UP_WR) && (stat_updates != '1))
        stat_updates <= stat_updates + 32'd1;
      if (init_done && bus.lk_valid && !lk_ready && (stat_stalls != '1))
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

  assign bus.lk_ready     = lk_ready;
  assign bus.upd_ready    = upd_ready;
  assign bus.lk_rsp_valid = rsp_valid;
  assign bus.lk_rsp_hist  = rsp_hist;
  assign bus.tbl_addr     = addr;
  assign bus.tbl_rd_en    = rd_en;
  assign bus.tbl_wr_en    = wr_en;
  assign bus.tbl_wdata    = wdata;

endmodule

// File: tb/tb_lht_access_scheduler.sv
`timescale 1ns/1ps
module tb_lht_access_scheduler;
  localparam int IDX_W  = 10;
  localparam int HIST_W = 10;
  localparam int QDEPTH = 4;
  localparam int N      = 1 << IDX_W;

  logic clock = 1'b0;
  logic reset;
  logic init_done;
`ifdef LHT_STATS_EN
  logic [31:0] stat_lookups, stat_updates, stat_stalls;
`endif

  lht_access_scheduler_if #(.IDX_W(IDX_W), .HIST_W(HIST_W)) bus ();

  lht_access_scheduler #(.IDX_W(IDX_W), .HIST_W(HIST_W), .QDEPTH(QDEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .init_done    (init_done),
`ifdef LHT_STATS_EN
    .stat_lookups (stat_lookups),
    .stat_updates (stat_updates),
    .stat_stalls  (stat_stalls),
`endif
    .bus          (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Table storage: 1-cycle read latency, starts with junk so the sweep matters.
  logic [HIST_W-1:0] mem [N];
  initial begin
    for (int i = 0; i < N; i++) mem[i] = 10'h2AA;
    bus.tbl_rdata = '0;
    forever begin
      @(posedge clock);
      if (bus.tbl_wr_en) mem[bus.tbl_addr] <= bus.tbl_wdata;
      if (bus.tbl_rd_en) bus.tbl_rdata <= mem[bus.tbl_addr];
    end
  end

  // Scoreboard queues
  logic [IDX_W+HIST_W-1:0] exp_wr[$];
  logic [HIST_W-1:0]       exp_rsp_hist[$];
  int                      exp_rsp_cyc[$];
  logic [HIST_W-1:0]       lk_exp_hist;

  int cyc = 0;
  int lk_acc = 0;
  int upd_wr = 0;

  // Every accepted lookup owes a response two cycles later carrying the
  // value the stimulus declared for it.
  always @(posedge clock) begin
    if (!reset && bus.lk_valid && bus.lk_ready) begin
      exp_rsp_hist.push_back(lk_exp_hist);
      exp_rsp_cyc.push_back(cyc + 2);
      lk_acc++;
    end
    if (!reset && bus.tbl_wr_en && init_done) upd_wr++;
    cyc++;
  end

  // Monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.tbl_rd_en && bus.tbl_wr_en) fail_now("rd_wr_same_cycle");
      if (bus.tbl_rd_en && !init_done)    fail_now("read_during_sweep");
      if (bus.tbl_wr_en) begin
        if (exp_wr.size() == 0) begin
          fail_now("unexpected_write");
          $display("  write addr 0x%0h data 0x%0h", bus.tbl_addr, bus.tbl_wdata);
        end else begin
          logic [IDX_W+HIST_W-1:0] e;
          e = exp_wr.pop_front();
          chk("tbl_write", {bus.tbl_addr, bus.tbl_wdata}, 32'(e));
        end
      end
      if (bus.lk_rsp_valid) begin
        if (exp_rsp_hist.size() == 0) fail_now("unexpected_lk_rsp");
        else begin
          chk("lk_rsp_hist", 32'(bus.lk_rsp_hist), 32'(exp_rsp_hist.pop_front()));
          chk("lk_rsp_latency", cyc, exp_rsp_cyc.pop_front());
        end
      end
    end
  end

  task automatic sweep_and_release();
    int n;
    for (int i = 0; i < N; i++) exp_wr.push_back({IDX_W'(i), HIST_W'(0)});
    @(posedge clock);
    #1 reset = 1'b0;
    n = 0;
    while (!init_done && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("init_done_cycle", n, N);
    @(negedge clock);
    chk("lk_ready_after_init", bus.lk_ready, 1);
    chk("upd_ready_after_init", bus.upd_ready, 1);
  endtask

  task automatic lookup(input logic [IDX_W-1:0] pc, input logic [HIST_W-1:0] h);
    int  n;
    logic acc;
    lk_exp_hist  = h;
    bus.lk_pc    = pc;
    bus.lk_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      acc = bus.lk_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!acc && n < 50);
    bus.lk_valid = 1'b0;
    if (!acc) fail_now("lookup_accept_timeout");
  endtask

  task automatic enqueue(input logic [IDX_W-1:0] pc, input logic t, output int waits);
    logic rdy;
    bus.upd_pc    = pc;
    bus.upd_taken = t;
    bus.upd_valid = 1'b1;
    waits = 0;
    do begin
      @(negedge clock);
      rdy = bus.upd_ready;
      @(posedge clock);
      #1;
      if (!rdy) waits++;
    end while (!rdy && waits < 50);
    bus.upd_valid = 1'b0;
    if (!rdy) fail_now("enqueue_timeout");
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_wr.size() != 0 || exp_rsp_hist.size() != 0) && n < 300) begin
      @(posedge clock);
      n++;
    end
    if (n >= 300) fail_now("drain_timeout");
    repeat (4) @(posedge clock);
    #1;
  endtask

  function automatic logic [IDX_W+HIST_W-1:0] wr(input int a, input int d);
    return {IDX_W'(a), HIST_W'(d)};
  endfunction

  initial begin
    int w, acc0, wr0, n;
    bus.lk_valid  = 1'b0;
    bus.lk_pc     = '0;
    bus.upd_valid = 1'b0;
    bus.upd_pc    = '0;
    bus.upd_taken = 1'b0;
    lk_exp_hist   = '0;
    reset         = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_init_done", init_done, 0);
    chk("rst_lk_ready", bus.lk_ready, 0);
    chk("rst_upd_ready", bus.upd_ready, 0);
    chk("rst_lk_rsp_valid", bus.lk_rsp_valid, 0);
    chk("rst_lk_rsp_hist", 32'(bus.lk_rsp_hist), 0);
    chk("rst_tbl_wr_en", bus.tbl_wr_en, 0);

    // Clear sweep
    sweep_and_release();

    // Plain lookup on a freshly cleared entry
    lookup(10'd5, 10'h000);
    wait_drain();

    // Read-modify-write history shifts, applied in order
    exp_wr.push_back(wr(5, 'h001));
    exp_wr.push_back(wr(5, 'h002));
    exp_wr.push_back(wr(5, 'h005));
    enqueue(10'd5, 1'b1, w);
    enqueue(10'd5, 1'b0, w);
    enqueue(10'd5, 1'b1, w);
    wait_drain();
    lookup(10'd5, 10'h005);
    wait_drain();

    // Lookups stream while the queue fills: urgency, full back-pressure
    exp_wr.push_back(wr(7, 'h001));
    exp_wr.push_back(wr(8, 'h001));
    exp_wr.push_back(wr(9, 'h000));
    exp_wr.push_back(wr(7, 'h003));
    exp_wr.push_back(wr(7, 'h006));
    lk_exp_hist  = '0;
    bus.lk_pc    = 10'd20;
    bus.lk_valid = 1'b1;
    enqueue(10'd7, 1'b1, w);
    enqueue(10'd8, 1'b1, w);
    enqueue(10'd9, 1'b0, w);
    acc0 = lk_acc;
    wr0  = upd_wr;
    enqueue(10'd7, 1'b1, w);
    chk("upd4_no_wait", w, 0);
    enqueue(10'd7, 1'b0, w);
    chk("upd5_held_while_full", 32'(w != 0), 1);
    chk("upd5_after_first_pop", upd_wr - wr0, 1);
    chk("lk_held_while_urgent", lk_acc - acc0, 0);
    n = 0;
    while (lk_acc == acc0 && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("lk_resumes_below_urgent", 32'(lk_acc > acc0), 1);
    @(posedge clock);
    #1 bus.lk_valid = 1'b0;
    wait_drain();
    lookup(10'd7, 10'h006);
    lookup(10'd8, 10'h001);
    wait_drain();

    // Reset while an update is in UP_WAIT with two queued
    enqueue(10'd10, 1'b1, w);
    enqueue(10'd11, 1'b1, w);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_upd_ready", bus.upd_ready, 0);
    chk("midrst_wr_en", bus.tbl_wr_en, 0);
    @(negedge clock);
    chk("midrst_init_done", init_done, 0);
    sweep_and_release();
    repeat (10) @(posedge clock);
    #1;
    lookup(10'd10, 10'h000);
    lookup(10'd7, 10'h000);
    wait_drain();
    chk("final_exp_wr_empty", exp_wr.size(), 0);
    chk("final_exp_rsp_empty", exp_rsp_hist.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
